// File: rtl/act_pkg.sv
// -----------------------------------------------------------------------------
// act_pkg -- shared definitions for the activation unit.
//   * mode_t   : function select encoding (sigmoid / relu / tanh / identity)
//   * state_t  : sequencing FSM state type
//   * fx_*     : PLAN breakpoint and offset constants as functions of the
//                number of fraction bits F, evaluated at elaboration time.
// Fractional constants are built as (k * 1.0) >> m, so a small F truncates
// toward zero instead of needing a negative shift amount.
// -----------------------------------------------------------------------------
package act_pkg;

    typedef enum logic [1:0] {
        MODE_SIGMOID = 2'b00,
        MODE_RELU    = 2'b01,
        MODE_TANH    = 2'b10,
        MODE_IDENT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // 1.0 in fixed point with f fraction bits
    function automatic longint fx_one(input int f);
        return longint'(1) << f;
    endfunction

    // 0.5
    function automatic longint fx_half(input int f);
        return fx_one(f) >> 1;
    endfunction

    // 0.625 = 5/8
    function automatic longint fx_0p625(input int f);
        return (5 * fx_one(f)) >> 3;
    endfunction

    // 0.84375 = 27/32
    function automatic longint fx_0p84375(input int f);
        return (27 * fx_one(f)) >> 5;
    endfunction

    // 2.375 = 19/8
    function automatic longint fx_2p375(input int f);
        return (19 * fx_one(f)) >> 3;
    endfunction

    // 5.0
    function automatic longint fx_5p0(input int f);
        return 5 * fx_one(f);
    endfunction

endpackage

// File: rtl/act_eval.sv
// -----------------------------------------------------------------------------
// act_eval -- combinational single-channel activation evaluator.
//   Parameters: S word width, F fraction bits (4 <= F <= S-4).
//   Ports:
//     x    in  [S-1:0]  signed fixed-point operand
//     mode in  mode_t   function select
//     y    out [S-1:0]  signed fixed-point result
//   Sigmoid is the PLAN piecewise-linear approximation; relu and identity are
//   trivial. Tanh (2*sigmoid(2x) - 1) is built only when ACT_UNIT_TANH_EN is
//   defined; otherwise mode 10 falls through to identity.
// -----------------------------------------------------------------------------
module act_eval
    import act_pkg::*;
#(
    parameter int S = 32,
    parameter int F = 16
) (
    input  logic [S-1:0] x,
    input  mode_t        mode,
    output logic [S-1:0] y
);

    localparam logic signed [S-1:0] ONE   = S'(fx_one(F));
    localparam logic signed [S-1:0] HALF  = S'(fx_half(F));
    localparam logic signed [S-1:0] C0625 = S'(fx_0p625(F));
    localparam logic signed [S-1:0] C0844 = S'(fx_0p84375(F));
    localparam logic signed [S-1:0] B2375 = S'(fx_2p375(F));
    localparam logic signed [S-1:0] B5    = S'(fx_5p0(F));
    localparam logic signed [S-1:0] MAXV  = {1'b0, {(S-1){1'b1}}};
    localparam logic signed [S-1:0] MINV  = {1'b1, {(S-1){1'b0}}};

    logic signed [S-1:0] xs;
    assign xs = x;

    function automatic logic signed [S-1:0] sigmoid(input logic signed [S-1:0] v);
        logic signed [S-1:0] a;
        logic signed [S-1:0] r;
        // |MIN| is not representable, so it saturates to MAX.
        a = v[S-1] ? ((v == MINV) ? MAXV : -v) : v;
        if (a >= B5)
            r = ONE;
        else if (a >= B2375)
            r = (a >>> 5) + C0844;
        else if (a >= ONE)
            r = (a >>> 3) + C0625;
        else
            r = (a >>> 2) + HALF;
        // Sigmoid is point-symmetric about (0, 0.5).
        if (v[S-1])
            r = ONE - r;
        return r;
    endfunction

`ifdef ACT_UNIT_TANH_EN
    logic signed [S-1:0] x2;
    // 2x overflows exactly when the two top bits differ.
    assign x2 = (xs[S-1] != xs[S-2]) ? (xs[S-1] ? MINV : MAXV) : (xs <<< 1);
`endif

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        y = x;
        case (mode)
            MODE_SIGMOID: y = sigmoid(xs);
            MODE_RELU:    y = xs[S-1] ? '0 : x;
`ifdef ACT_UNIT_TANH_EN
            MODE_TANH:    y = (sigmoid(x2) <<< 1) - ONE;
`endif
            default:      y = x;
        endcase
    end

endmodule

// File: rtl/act_unit.sv
// -----------------------------------------------------------------------------
// act_unit -- N-channel activation unit with one shared evaluator.
//   Parameters: S word width, N channel count, F fraction bits (4..S-4).
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     x      in   [S*N-1:0] packed operands, channel i at [S*i +: S]
//     start  in   job request, honoured only while idle
//     mode   in   [1:0] 00 sigmoid, 01 relu, 10 tanh, 11 identity
//     y      out  [S*N-1:0] packed results, same packing as x
//     done   out  one-cycle pulse, N+1 cycles after the accepting edge
//     busy   out  high from the cycle after accept until done
//   Optional feature macro: ACT_UNIT_TANH_EN (tanh for mode 10; otherwise
//   mode 10 is identity).
//   Sequencing: IDLE -> CALC (one channel per cycle, channel 0 first) ->
//   DONE -> IDLE. done is registered off DONE so it appears the cycle the
//   FSM has already returned to IDLE, which is why busy is low alongside it.
// -----------------------------------------------------------------------------
module act_unit
    import act_pkg::*;
#(
    parameter int S = 32,
    parameter int N = 2,
    parameter int F = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [S*N-1:0] x,
    input  logic           start,
    input  logic [1:0]     mode,
    output logic [S*N-1:0] y,
    output logic           done,
    output logic           busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [S*N-1:0] x_reg;
    mode_t          mode_reg;
    logic [S-1:0]   ev_in;
    logic [S-1:0]   ev_out;
    logic           last;

    assign last  = (cnt == CW'(N - 1));
    assign ev_in = x_reg[cnt*S +: S];
    assign busy  = (state != ST_IDLE);

    act_eval #(
        .S (S),
        .F (F)
    ) u_eval (
        .x    (ev_in),
        .mode (mode_reg),
        .y    (ev_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (last)  state_nxt = ST_DONE;
            ST_DONE:            state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: the result and capture registers are all reset because a
    // reset must leave y at zero and abort any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg    <= '0;
            mode_reg <= MODE_SIGMOID;
            cnt      <= '0;
            y        <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_IDLE && start) begin
                x_reg    <= x;
                mode_reg <= mode_t'(mode);
                cnt      <= '0;
            end
            if (state == ST_CALC) begin
                y[cnt*S +: S] <= ev_out;
                cnt           <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_act_unit.sv
// -----------------------------------------------------------------------------
// tb_act_unit -- self-checking bench for act_unit (S=32, N=2, F=16).
// Expected results come from a reference model written with integer
// arithmetic on the PLAN rules (breakpoints as fractions of 1.0).
// -----------------------------------------------------------------------------
module tb_act_unit;

    localparam int S = 32;
    localparam int N = 2;
    localparam int F = 16;

    localparam longint ONE  = longint'(1) << F;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic           clk;
    logic           rst_n;
    logic [S*N-1:0] x;
    logic           start;
    logic [1:0]     mode;
    logic [S*N-1:0] y;
    logic           done;
    logic           busy;

    int n_cmp;
    int n_bad;

    act_unit #(.S(S), .N(N), .F(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .start (start),
        .mode  (mode),
        .y     (y),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Sigmoid approximation on a real-valued scale of 1.0 == ONE.
    function automatic longint sig_ref(input longint v);
        longint a;
        longint r;
        a = (v < 0) ? -v : v;
        if (a > MAXV) a = MAXV;
        if (a >= 5 * ONE)            r = ONE;
        else if (8 * a >= 19 * ONE)  r = a / 32 + (27 * ONE) / 32;
        else if (a >= ONE)           r = a / 8 + (5 * ONE) / 8;
        else                         r = a / 4 + ONE / 2;
        if (v < 0) r = ONE - r;
        return r;
    endfunction

    function automatic logic [31:0] act_ref(input logic [31:0] xw, input logic [1:0] m);
        logic signed [31:0] xs;
        longint v;
        longint r;
        xs = xw;
        v  = xs;
        case (m)
            2'b00: r = sig_ref(v);
            2'b01: r = (v < 0) ? 0 : v;
`ifdef ACT_UNIT_TANH_EN
            2'b10: begin
                longint t;
                t = 2 * v;
                if (t > MAXV) t = MAXV;
                if (t < MINV) t = MINV;
                r = 2 * sig_ref(t) - ONE;
            end
`endif
            default: r = v;
        endcase
        return r[31:0];
    endfunction

    task automatic run_job(input logic [S*N-1:0] xv, input logic [1:0] m,
                           input bit repulse, input string tag);
        logic [S*N-1:0] exp_y;
        int cyc;
        for (int ch = 0; ch < N; ch++)
            exp_y[ch*S +: S] = act_ref(xv[ch*S +: S], m);
        @(negedge clk);
        x = xv; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (repulse) begin
            x = ~xv; mode = m ^ 2'b01; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 1;
        end
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(N + 1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        for (int ch = 0; ch < N; ch++)
            check($sformatf("%s_y%0d", tag, ch), 64'(y[ch*S +: S]), 64'(exp_y[ch*S +: S]));
        @(negedge clk);
        check({tag, "_done_width"}, 64'(done), 64'd0);
        check({tag, "_y_stable"}, y, exp_y);
    endtask

    initial begin
        bit seen_done;
        logic [S*N-1:0] rx;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        x     = '0;
        #1;
        check("rst_y", y, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, channel 0 in the low word.
        run_job({32'hFFFC3334, 32'h00050000}, 2'b00, 1'b0, "sig_5_m38");
        run_job({32'h80000000, 32'h00000000}, 2'b00, 1'b0, "sig_0_min");
        run_job({32'h00012000, 32'hFFFC3334}, 2'b01, 1'b0, "relu");
        run_job({32'h00020000, 32'h00008000}, 2'b10, 1'b0, "mode10");
        run_job({32'h80000000, 32'h7FFFFFFF}, 2'b10, 1'b0, "mode10_sat");
        run_job({32'h00026000, 32'h00010000}, 2'b00, 1'b0, "sig_bp_hi");
        run_job({32'hFFFF0000, 32'h00025FFF}, 2'b00, 1'b0, "sig_bp_lo");
        run_job({32'hFFFB0000, 32'h0004FFFF}, 2'b00, 1'b0, "sig_bp_5");
        run_job({32'h12345678, 32'hDEADBEEF}, 2'b11, 1'b0, "ident");
        run_job({32'h00030000, 32'hFFFE8000}, 2'b00, 1'b1, "repulse");

        // Reset during CALC: aborts the job, start held in reset is ignored.
        @(negedge clk);
        x = {32'h00010000, 32'h00020000}; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        #1;
        check("rst_mid_y", y, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        @(negedge clk);
        check("rst_start_ignored", 64'(busy), 64'd0);
        rst_n = 1'b1; start = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("rst_no_done", 64'(seen_done), 64'd0);
        check("rst_after_y", y, 64'd0);
        run_job({32'hFFFC3334, 32'h00050000}, 2'b00, 1'b0, "after_rst");

        // Randomized jobs: half full-range words, half near the breakpoints.
        for (int k = 0; k < 40; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 1) == 0)
                    rx[ch*S +: S] = $urandom;
                else
                    rx[ch*S +: S] = 32'(int'($urandom_range(0, 786432)) - 393216);
            end
            run_job(rx, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
